// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Purpose  : Serial pattern transmitter. Accepts a W-bit pattern with a
//            repeat count and an inter-frame gap through a start/ready
//            handshake, then shifts the pattern out MSB-first, one bit per
//            clock, repeating it the requested number of times.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            start         - transfer request, accepted while ready=1
//            pattern       - W-bit pattern, sampled on accept
//            repeat_n      - number of frames, sampled on accept
//            gap           - idle cycles between frames, sampled on accept
//            abort         - synchronous cancel of a running transfer
//            ready         - idle, start will be accepted
//            x / x_valid   - serial data bit and its qualifier
//            frame_start   - high on the MSB of every frame
//            done          - one-cycle pulse after the final bit
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int W     = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int IDX_W = $clog2(W);
    localparam logic [IDX_W-1:0] c_IDX_TOP  = IDX_W'(W - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] c_GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Registered state
    state_t             r_state;
    logic [W-1:0]       r_pat;
    logic [CNT_W-1:0]   r_frames_left;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   r_gap_cnt;
    // r_idx is the index of the bit currently presented on x
    logic [IDX_W-1:0]   r_idx;
    logic               r_ready;
    logic               r_x;
    logic               r_x_valid;
    logic               r_frame_start;
    logic               r_done;

    // Next-state values
    state_t             w_state;
    logic [W-1:0]       w_pat;
    logic [CNT_W-1:0]   w_frames_left;
    logic [GAP_W-1:0]   w_gap;
    logic [GAP_W-1:0]   w_gap_cnt;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_idx_dec;
    logic               w_ready;
    logic               w_x;
    logic               w_x_valid;
    logic               w_frame_start;
    logic               w_done;

    assign w_idx_dec = r_idx - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pat         <= '0;
            r_frames_left <= '0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
            r_idx         <= '0;
            r_ready       <= 1'b1;
            r_x           <= 1'b0;
            r_x_valid     <= 1'b0;
            r_frame_start <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_pat         <= w_pat;
            r_frames_left <= w_frames_left;
            r_gap         <= w_gap;
            r_gap_cnt     <= w_gap_cnt;
            r_idx         <= w_idx;
            r_ready       <= w_ready;
            r_x           <= w_x;
            r_x_valid     <= w_x_valid;
            r_frame_start <= w_frame_start;
            r_done        <= w_done;
        end
    end

    // Outputs are computed one cycle ahead so that every port is a flop:
    // the w_* output values describe the cycle following the coming edge.
    always_comb begin
        w_state       = r_state;
        w_pat         = r_pat;
        w_frames_left = r_frames_left;
        w_gap         = r_gap;
        w_gap_cnt     = r_gap_cnt;
        w_idx         = r_idx;
        w_ready       = 1'b0;
        w_x           = 1'b0;
        w_x_valid     = 1'b0;
        w_frame_start = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                // abort in IDLE suppresses a simultaneous start
                if (start && !abort) begin
                    w_pat = pattern;
                    w_gap = gap;
                    if (repeat_n == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state       = S_SHIFT;
                        w_frames_left = repeat_n;
                        w_idx         = c_IDX_TOP;
                        w_ready       = 1'b0;
                        w_x           = pattern[W-1];
                        w_x_valid     = 1'b1;
                        w_frame_start = 1'b1;
                    end
                end
            end

            S_SHIFT: begin
                if (abort) begin
                    w_state       = S_IDLE;
                    w_frames_left = '0;
                    w_gap_cnt     = '0;
                    w_ready       = 1'b1;
                end else if (r_idx != '0) begin
                    w_idx     = w_idx_dec;
                    w_x       = r_pat[w_idx_dec];
                    w_x_valid = 1'b1;
                end else if (r_frames_left <= c_CNT_ONE) begin
                    // last bit of last frame
                    w_state       = S_IDLE;
                    w_frames_left = '0;
                    w_ready       = 1'b1;
                    w_done        = 1'b1;
                end else begin
                    w_frames_left = r_frames_left - c_CNT_ONE;
                    if (r_gap == '0) begin
                        w_idx         = c_IDX_TOP;
                        w_x           = r_pat[W-1];
                        w_x_valid     = 1'b1;
                        w_frame_start = 1'b1;
                    end else begin
                        w_state   = S_GAP;
                        w_gap_cnt = r_gap;
                    end
                end
            end

            S_GAP: begin
                if (abort) begin
                    w_state       = S_IDLE;
                    w_frames_left = '0;
                    w_gap_cnt     = '0;
                    w_ready       = 1'b1;
                end else if (r_gap_cnt <= c_GAP_ONE) begin
                    // r_gap_cnt counts remaining idle cycles including this one
                    w_state       = S_SHIFT;
                    w_gap_cnt     = '0;
                    w_idx         = c_IDX_TOP;
                    w_x           = r_pat[W-1];
                    w_x_valid     = 1'b1;
                    w_frame_start = 1'b1;
                end else begin
                    w_gap_cnt = r_gap_cnt - c_GAP_ONE;
                end
            end

            default: begin
                w_state = S_IDLE;
                w_ready = 1'b1;
            end
        endcase
    end

    assign ready       = r_ready;
    assign x           = r_x;
    assign x_valid     = r_x_valid;
    assign frame_start = r_frame_start;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Purpose  : Self-checking bench for seq_pattern_tx. Stimulus pushes the
//            hand-computed per-cycle output vectors {ready, x_valid, x,
//            frame_start, done} into a queue; a monitor on the falling edge
//            pops one vector per cycle and compares, and flags any x_valid
//            or done seen while nothing is expected. A 1010 Mealy detector
//            observes the serial stream for the loopback case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [7:0] repeat_n;
    logic [3:0] gap;
    logic       ready;
    logic       x;
    logic       x_valid;
    logic       frame_start;
    logic       done;

    seq_pattern_tx #(.W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pattern     (pattern),
        .repeat_n    (repeat_n),
        .gap         (gap),
        .abort       (abort),
        .ready       (ready),
        .x           (x),
        .x_valid     (x_valid),
        .frame_start (frame_start),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [4:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one expected vector per cycle while the queue holds any
    always @(negedge clk) begin
        logic [4:0] act;
        logic [4:0] e;
        act = {ready, x_valid, x, frame_start, done};
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL stream cyc=%0d rdy/xv/x/fs/done got %b want %b", cyc, act, e);
                end
            end else if (x_valid !== 1'b0 || done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected cyc=%0d x_valid=%b done=%b want 0 0", cyc, x_valid, done);
            end
        end
    end

    // 1010 Mealy detector fed from the serial stream
    logic       det_en = 1'b0;
    logic [1:0] det_st;
    int         det_hits;
    int         det_pos;
    int         det_last;

    always @(posedge clk) begin
        if (!det_en) begin
            det_st   <= 2'd0;
            det_hits <= 0;
            det_pos  <= 0;
            det_last <= 0;
        end else if (x_valid) begin
            det_pos <= det_pos + 1;
            case (det_st)
                2'd0: det_st <= x ? 2'd1 : 2'd0;
                2'd1: det_st <= x ? 2'd1 : 2'd2;
                2'd2: det_st <= x ? 2'd3 : 2'd0;
                default: begin
                    if (x) begin
                        det_st <= 2'd1;
                    end else begin
                        det_st   <= 2'd2;
                        det_hits <= det_hits + 1;
                        det_last <= det_pos + 1;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Push n bits (MSB of each mask first) followed by the done cycle
    task automatic push_vec(input int n, input logic [31:0] v, input logic [31:0] xs,
                            input logic [31:0] fs);
        for (int i = n - 1; i >= 0; i--)
            exp_q.push_back({1'b0, v[i], xs[i], fs[i], 1'b0});
        exp_q.push_back(5'b10001);
    endtask

    task automatic xfer(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
        pattern  = p;
        repeat_n = r;
        gap      = g;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending=%0d want 0 after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        pattern  = 4'd0;
        repeat_n = 8'd0;
        gap      = 4'd0;
        repeat (3) tick();

        checks++;
        if ({ready, x_valid, x, frame_start, done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset got %b want 10000", {ready, x_valid, x, frame_start, done});
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // Basic transfer: 1010 x2, no gap
        push_vec(8, 32'hFF, 32'b10101010, 32'b10001000);
        xfer(4'b1010, 8'd2, 4'd0);
        drain(40);

        // Gap insertion, with a start pulsed while busy (must be ignored)
        push_vec(16, 32'b1111001111001111, 32'b1100001100001100, 32'b1000001000001000);
        xfer(4'b1100, 8'd3, 4'd2);
        tick();
        tick();
        pattern  = 4'b0011;
        repeat_n = 8'd1;
        gap      = 4'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        drain(60);

        // Zero repeat: done in the cycle after accept, no bits
        exp_q.push_back(5'b10001);
        xfer(4'b1111, 8'd0, 4'd3);
        drain(20);

        // Single frame: gap setting has no effect
        push_vec(4, 32'hF, 32'b0111, 32'b1000);
        xfer(4'b0111, 8'd1, 4'd5);
        drain(20);

        // Abort after bit 2 of frame 1
        exp_q.push_back(5'b01110);
        exp_q.push_back(5'b01000);
        exp_q.push_back(5'b10000);
        exp_q.push_back(5'b10000);
        xfer(4'b1010, 8'd2, 4'd0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drain(20);
        repeat (10) tick();

        // Reset after bit 2 of frame 1
        exp_q.push_back(5'b01110);
        exp_q.push_back(5'b01000);
        exp_q.push_back(5'b10000);
        exp_q.push_back(5'b10000);
        xfer(4'b1010, 8'd2, 4'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drain(20);
        repeat (10) tick();

        // abort together with start in IDLE: start ignored
        repeat (3) exp_q.push_back(5'b10000);
        pattern  = 4'b1001;
        repeat_n = 8'd2;
        gap      = 4'd0;
        abort    = 1'b1;
        start    = 1'b1;
        tick();
        abort    = 1'b0;
        start    = 1'b0;
        drain(20);

        // Back-to-back: start held, second accepted on the done edge
        push_vec(4, 32'hF, 32'b1010, 32'b1000);
        push_vec(4, 32'hF, 32'b0110, 32'b1000);
        pattern  = 4'b1010;
        repeat_n = 8'd1;
        gap      = 4'd0;
        start    = 1'b1;
        tick();
        tick();
        pattern  = 4'b0110;
        repeat (4) tick();
        start    = 1'b0;
        drain(40);

        // Loopback into a 1010 detector: 101010101010 -> hits at bits 4,6,8,10,12
        det_en = 1'b1;
        push_vec(12, 32'hFFF, 32'b101010101010, 32'b100010001000);
        xfer(4'b1010, 8'd3, 4'd0);
        drain(40);
        checks++;
        if (det_hits != 5) begin
            errors++;
            $display("FAIL loop_hits got %0d want 5", det_hits);
        end
        checks++;
        if (det_last != 12) begin
            errors++;
            $display("FAIL loop_last got %0d want 12", det_last);
        end
        det_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
